// File: rtl/multicycle_control_fsm.sv
// Control sequencer for a multicycle MIPS datapath: per-state control decode,
// memory-ready stalls with timeout abort, and a retired-instruction counter.
module multicycle_control_fsm #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           OP,
  input  logic                 Zero,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 PCWriteCondEQ,
  output logic                 PCWriteCondNE,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 MemtoReg,
  output logic                 RegDst,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [3:0]           ALUOp,
  output logic [1:0]           PCSource,
  output logic                 IllegalOp,
  output logic                 MemError,
  output logic [CNT_WIDTH-1:0] InstrRetired
);

  localparam int WAIT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WAIT_W-1:0] TO_VAL = WAIT_W'(TIMEOUT_CYCLES);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [WAIT_W-1:0]     r_wait;
  logic                  r_mem_error;
  logic [CNT_WIDTH-1:0]  r_retired;
  logic                  w_to_hit;
  logic                  w_stall;
  logic                  w_timeout;
  logic                  w_retire;
  logic                  w_unused_zero;

  // Zero is gated with PCWriteCondEQ/NE in the datapath, not consumed here.
  assign w_unused_zero = Zero;
  assign w_to_hit      = (TIMEOUT_CYCLES != 32'sd0) && (r_wait == TO_VAL);
  assign MemError      = r_mem_error;
  assign InstrRetired  = r_retired;

  // State register, stall counter, sticky error and retirement counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_wait      <= {WAIT_W{1'b0}};
      r_mem_error <= 1'b0;
      r_retired   <= {CNT_WIDTH{1'b0}};
    end else begin
      r_state <= w_next;
      if (w_stall && (TIMEOUT_CYCLES != 32'sd0)) begin
        r_wait <= r_wait + WAIT_W'(1);
      end else begin
        r_wait <= {WAIT_W{1'b0}};
      end
      if (w_timeout) begin
        r_mem_error <= 1'b1;
      end
      if (w_retire) begin
        r_retired <= r_retired + CNT_WIDTH'(1);
      end
    end
  end

  // Next-state and control-word decode; every output defaults to 0.
  always_comb begin
    w_next        = r_state;
    w_stall       = 1'b0;
    w_timeout     = 1'b0;
    w_retire      = 1'b0;
    PCWrite       = 1'b0;
    PCWriteCondEQ = 1'b0;
    PCWriteCondNE = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUOp         = 4'b0000;
    PCSource      = 2'b00;
    IllegalOp     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next = S_FETCH;
      end
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          w_next  = S_DECODE;
        end else if (w_to_hit) begin
          MemRead   = 1'b0;
          w_timeout = 1'b1;
          w_next    = S_FETCH;
        end else begin
          w_stall = 1'b1;
          w_next  = S_FETCH;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (OP)
          OP_R:           w_next = S_R_EXEC;
          OP_ADDI, OP_ORI: w_next = S_I_EXEC;
          OP_LW, OP_SW:   w_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_J:           w_next = S_JUMP;
          default: begin
            IllegalOp = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (OP == OP_SW) begin
          w_next = S_MEM_WRITE;
        end else begin
          w_next = S_MEM_READ;
        end
      end
      S_MEM_READ: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (MemReady) begin
          w_next = S_MEM_WB;
        end else if (w_to_hit) begin
          MemRead   = 1'b0;
          w_timeout = 1'b1;
          w_next    = S_FETCH;
        end else begin
          w_stall = 1'b1;
        end
      end
      S_MEM_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEM_WRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (MemReady) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else if (w_to_hit) begin
          MemWrite  = 1'b0;
          w_timeout = 1'b1;
          w_next    = S_FETCH;
        end else begin
          w_stall = 1'b1;
        end
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 4'b0111;
        w_next  = S_R_WB;
      end
      S_R_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (OP == OP_ORI) begin
          ALUOp = 4'b0010;
        end else begin
          ALUOp = 4'b0000;
        end
        w_next = S_I_WB;
      end
      S_I_WB: begin
        RegWrite = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 4'b0001;
        PCSource = 2'b01;
        if (OP == OP_BNE) begin
          PCWriteCondNE = 1'b1;
        end else begin
          PCWriteCondEQ = 1'b1;
        end
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench: expected control words per cycle are generated from each
// instruction's phase script (with stalls/aborts) and checked every cycle.
module tb_multicycle_control_fsm;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  OP;
  logic        Zero;
  logic        MemReady;
  logic        PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite;
  logic        IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp, MemError;
  logic [1:0]  ALUSrcB, PCSource;
  logic [3:0]  ALUOp;
  logic [31:0] InstrRetired;

  multicycle_control_fsm #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .OP(OP), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCondEQ(PCWriteCondEQ), .PCWriteCondNE(PCWriteCondNE),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .IllegalOp(IllegalOp),
    .MemError(MemError), .InstrRetired(InstrRetired)
  );

  always #5 clk = ~clk;

  logic [19:0] dut_w;
  assign dut_w = {PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp};

  int          n_checks = 0;
  int          n_err    = 0;
  int          n_cyc    = 0;
  int          n_mrd    = 0;
  bit          chk_en   = 1'b0;
  logic [19:0] exp_w    = 20'h0;
  logic [31:0] exp_cnt  = 32'd0;
  logic        exp_err  = 1'b0;

  logic [19:0] W_IDLE, W_FETCH_WAIT, W_FETCH_GO, W_FETCH_AB, W_DECODE, W_DEC_ILL, W_MADDR;
  logic [19:0] W_MREAD, W_MREAD_AB, W_MWB, W_MWRITE, W_MWRITE_AB, W_REXEC, W_RWB;
  logic [19:0] W_IEXEC_ADD, W_IEXEC_OR, W_IWB, W_BR_EQ, W_BR_NE, W_JMP;

  function automatic logic [19:0] word(input logic pcw, input logic eq, input logic ne,
      input logic iord, input logic mr, input logic mw, input logic irw, input logic m2r,
      input logic rdst, input logic rw, input logic srca, input logic [1:0] srcb,
      input logic [3:0] aop, input logic [1:0] pcs, input logic ill);
    return {pcw, eq, ne, iord, mr, mw, irw, m2r, rdst, rw, srca, srcb, aop, pcs, ill};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Per-cycle comparison of the DUT against the bench's expected control word and counters.
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (dut_w !== exp_w) begin
        n_err++;
        $display("FAIL ctrl_word cycle=%0d got=%05h expected=%05h", n_cyc, dut_w, exp_w);
      end
      n_checks++;
      if (MemError !== exp_err) begin
        n_err++;
        $display("FAIL mem_error cycle=%0d got=%0b expected=%0b", n_cyc, MemError, exp_err);
      end
      n_checks++;
      if (InstrRetired !== exp_cnt) begin
        n_err++;
        $display("FAIL retired cycle=%0d got=%0d expected=%0d", n_cyc, InstrRetired, exp_cnt);
      end
      if (IorD && MemRead) n_mrd++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic mr, input logic [19:0] w, input bit retire, input bit abort);
    MemReady = mr;
    Zero     = rnd();
    exp_w    = w;
    chk_en   = 1'b1;
    @(posedge clk);
    #1;
    n_cyc++;
    if (retire) exp_cnt++;
    if (abort) exp_err = 1'b1;
  endtask

  task automatic mem_phase(input logic [19:0] w_wait, input logic [19:0] w_done,
      input logic [19:0] w_abort, input int stall, input bit retire_done, output bit aborted);
    if (stall > TO) begin
      for (int i = 0; i < TO; i++) cyc(1'b0, w_wait, 1'b0, 1'b0);
      cyc(1'b0, w_abort, 1'b0, 1'b1);
      aborted = 1'b1;
    end else begin
      for (int i = 0; i < stall; i++) cyc(1'b0, w_wait, 1'b0, 1'b0);
      cyc(1'b1, w_done, retire_done, 1'b0);
      aborted = 1'b0;
    end
  endtask

  task automatic run(input logic [5:0] op, input int fstall, input int mstall);
    bit ab;
    OP = op;
    mem_phase(W_FETCH_WAIT, W_FETCH_GO, W_FETCH_AB, fstall, 1'b0, ab);
    if (ab) return;
    if (!(op inside {6'b000000, 6'b001000, 6'b001101, 6'b100011, 6'b101011,
                     6'b000100, 6'b000101, 6'b000010})) begin
      cyc(rnd(), W_DEC_ILL, 1'b0, 1'b0);
      return;
    end
    cyc(rnd(), W_DECODE, 1'b0, 1'b0);
    case (op)
      6'b000000: begin
        cyc(rnd(), W_REXEC, 1'b0, 1'b0);
        cyc(rnd(), W_RWB, 1'b1, 1'b0);
      end
      6'b001000, 6'b001101: begin
        cyc(rnd(), (op == 6'b001101) ? W_IEXEC_OR : W_IEXEC_ADD, 1'b0, 1'b0);
        cyc(rnd(), W_IWB, 1'b1, 1'b0);
      end
      6'b100011: begin
        cyc(rnd(), W_MADDR, 1'b0, 1'b0);
        mem_phase(W_MREAD, W_MREAD, W_MREAD_AB, mstall, 1'b0, ab);
        if (!ab) cyc(rnd(), W_MWB, 1'b1, 1'b0);
      end
      6'b101011: begin
        cyc(rnd(), W_MADDR, 1'b0, 1'b0);
        mem_phase(W_MWRITE, W_MWRITE, W_MWRITE_AB, mstall, 1'b1, ab);
      end
      6'b000100: cyc(rnd(), W_BR_EQ, 1'b1, 1'b0);
      6'b000101: cyc(rnd(), W_BR_NE, 1'b1, 1'b0);
      default:   cyc(rnd(), W_JMP, 1'b1, 1'b0);
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    //                 pcw eq ne iord mr mw irw m2r rdst rw srca srcb   aop      pcs   ill
    W_IDLE       = 20'h0;
    W_FETCH_WAIT = word(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 4'b0000, 2'b00, 0);
    W_FETCH_GO   = word(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 4'b0000, 2'b00, 0);
    W_FETCH_AB   = word(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 4'b0000, 2'b00, 0);
    W_DECODE     = word(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 4'b0000, 2'b00, 0);
    W_DEC_ILL    = word(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 4'b0000, 2'b00, 1);
    W_MADDR      = word(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'b0000, 2'b00, 0);
    W_MREAD      = word(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b00, 0);
    W_MREAD_AB   = word(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b00, 0);
    W_MWB        = word(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 4'b0000, 2'b00, 0);
    W_MWRITE     = word(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b00, 0);
    W_MWRITE_AB  = word(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b00, 0);
    W_REXEC      = word(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'b0111, 2'b00, 0);
    W_RWB        = word(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 4'b0000, 2'b00, 0);
    W_IEXEC_ADD  = word(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'b0000, 2'b00, 0);
    W_IEXEC_OR   = word(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'b0010, 2'b00, 0);
    W_IWB        = word(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 4'b0000, 2'b00, 0);
    W_BR_EQ      = word(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'b0001, 2'b01, 0);
    W_BR_NE      = word(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'b0001, 2'b01, 0);
    W_JMP        = word(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b10, 0);

    reset = 1'b0; OP = 6'b000000; Zero = 1'b0; MemReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {12'd0, dut_w}, 32'd0);
    chk("reset_count", InstrRetired, 32'd0);
    chk("reset_memerror", {31'd0, MemError}, 32'd0);
    reset = 1'b1;
    cyc(rnd(), W_IDLE, 1'b0, 1'b0);

    c0 = n_cyc;
    run(6'b000000, 0, 0);
    chk("add_cpi", n_cyc - c0, 32'd4);
    chk("add_retired", InstrRetired, 32'd1);

    c0 = n_cyc; n_mrd = 0;
    run(6'b100011, 0, 3);
    chk("lw_cpi", n_cyc - c0, 32'd8);
    chk("lw_memread_cycles", n_mrd, 32'd4);

    c0 = n_cyc;
    run(6'b000100, 0, 0);
    chk("beq_cpi", n_cyc - c0, 32'd3);
    c0 = n_cyc;
    run(6'b000101, 0, 0);
    chk("bne_cpi", n_cyc - c0, 32'd3);

    run(6'b111111, 0, 0);
    chk("illegal_not_counted", InstrRetired, 32'd4);

    run(6'b001000, 0, 0);
    run(6'b001101, 0, 0);
    run(6'b101011, 0, 1);
    run(6'b000010, 0, 0);
    run(6'b100011, 0, TO);
    run(6'b000000, 2, 0);
    chk("mix_retired", InstrRetired, 32'd10);
    chk("mix_memerror", {31'd0, MemError}, 32'd0);

    c0 = n_cyc;
    run(6'b000000, TO + 1, 0);
    chk("fetch_abort_cycles", n_cyc - c0, 32'd5);
    chk("fetch_abort_memerror", {31'd0, MemError}, 32'd1);
    run(6'b000000, 0, 0);
    run(6'b101011, 0, TO + 1);
    run(6'b100011, 0, TO + 1);
    run(6'b000010, 0, 0);
    chk("abort_retired", InstrRetired, 32'd12);
    chk("memerror_sticky", {31'd0, MemError}, 32'd1);

    OP = 6'b101011;
    cyc(1'b1, W_FETCH_GO, 1'b0, 1'b0);
    cyc(rnd(), W_DECODE, 1'b0, 1'b0);
    cyc(rnd(), W_MADDR, 1'b0, 1'b0);
    cyc(1'b0, W_MWRITE, 1'b0, 1'b0);
    cyc(1'b0, W_MWRITE, 1'b0, 1'b0);
    chk_en = 1'b0;
    MemReady = 1'b1;
    #2;
    chk("sw_memwrite_before_reset", {31'd0, MemWrite}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_memwrite", {31'd0, MemWrite}, 32'd0);
    chk("rst_outputs", {12'd0, dut_w}, 32'd0);
    chk("rst_count", InstrRetired, 32'd0);
    chk("rst_memerror", {31'd0, MemError}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_outputs", {12'd0, dut_w}, 32'd0);
    chk("rst_hold_count", InstrRetired, 32'd0);
    reset = 1'b1;
    exp_cnt = 32'd0;
    exp_err = 1'b0;
    cyc(rnd(), W_IDLE, 1'b0, 1'b0);
    run(6'b000000, 0, 0);
    chk("post_reset_retired", InstrRetired, 32'd1);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
